// File: rtl/gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_debounce
// Description : Per-pin conditioning for raw GPIO pads. Each pin is brought
//               into the clk domain through a SYNC_STAGES-deep flop chain and
//               then filtered by a consecutive-cycle debounce counter. A new
//               level is accepted only after it has differed from the current
//               output for Neff consecutive edges, where Neff is
//               debounce_cycles, or 1 when the filter is bypassed or the
//               threshold is zero.
//
// Ports       : clk              system clock
//               rst              asynchronous active-high reset
//               pin_in[W]        raw asynchronous pad inputs
//               debounce_en      1 = filter active, 0 = synchronise only
//               debounce_cycles  consecutive differing cycles to accept
//               pin_out[W]       synchronised, debounced level (registered)
//               changed[W]       1-cycle pulse when pin_out[i] takes a new value
//
// Revision    : 1.0  initial release
// ============================================================================
module gpio_input_debounce #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pin_in,
    input  logic                 debounce_en,
    input  logic [CNT_WIDTH-1:0] debounce_cycles,
    output logic [WIDTH-1:0]     pin_out,
    output logic [WIDTH-1:0]     changed
);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Effective threshold, one bit wider than the counter so that the
    // cnt+1 comparison stays exact at the all-ones threshold.
    logic [CNT_WIDTH:0] w_neff;
    logic               w_neff_is_one;

    assign w_neff = (!debounce_en || (debounce_cycles == '0))
                  ? (CNT_WIDTH+1)'(1)
                  : {1'b0, debounce_cycles};
    assign w_neff_is_one = (w_neff == (CNT_WIDTH+1)'(1));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] r_sync;
            state_t                 r_state;
            state_t                 w_state_nxt;
            logic [CNT_WIDTH-1:0]   r_cnt;
            logic [CNT_WIDTH-1:0]   w_cnt_nxt;
            logic [CNT_WIDTH:0]     w_cnt_inc;
            logic                   r_out;
            logic                   r_chg;
            logic                   w_out_nxt;
            logic                   w_chg_nxt;
            logic                   w_sync_q;
            logic                   w_diff;

            // Plain flop chain: nothing between stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in[gi]};
                end
            end

            assign w_sync_q  = r_sync[SYNC_STAGES-1];
            assign w_diff    = (w_sync_q != r_out);
            assign w_cnt_inc = {1'b0, r_cnt} + (CNT_WIDTH+1)'(1);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                    r_chg   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_out   <= w_out_nxt;
                    r_chg   <= w_chg_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_out_nxt   = r_out;
                w_chg_nxt   = 1'b0;
                case (r_state)
                    ST_STABLE: begin
                        w_cnt_nxt = '0;
                        if (w_diff) begin
                            if (w_neff_is_one) begin
                                w_out_nxt = w_sync_q;
                                w_chg_nxt = 1'b1;
                            end else begin
                                w_cnt_nxt   = CNT_WIDTH'(1);
                                w_state_nxt = ST_PENDING;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (!w_diff) begin
                            // Input fell back before the threshold: glitch.
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_STABLE;
                        end else if (w_cnt_inc >= w_neff) begin
                            // >= so a threshold lowered mid-count accepts at once.
                            w_out_nxt   = w_sync_q;
                            w_chg_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_STABLE;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[CNT_WIDTH-1:0];
                        end
                    end
                    default: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end
                endcase
            end

            assign pin_out[gi] = r_out;
            assign changed[gi] = r_chg;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_input_debounce
// Description : Randomised and directed stimulus for gpio_input_debounce with a
//               queue-based scoreboard. The reference model tracks, per pin,
//               how many consecutive edges the synchronised input has differed
//               from the output, and accepts once that run reaches the
//               effective threshold.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_input_debounce;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_WIDTH   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WIDTH-1:0]     pin_in = '0;
    logic                 debounce_en = 1'b1;
    logic [CNT_WIDTH-1:0] debounce_cycles = 16'd4;
    logic [WIDTH-1:0]     pin_out;
    logic [WIDTH-1:0]     changed;

    gpio_input_debounce #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pin_in          (pin_in),
        .debounce_en     (debounce_en),
        .debounce_cycles (debounce_cycles),
        .pin_out         (pin_out),
        .changed         (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic [WIDTH-1:0] chg;
    } exp_t;

    exp_t             exp_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc_no  = 0;

    // Reference state: pad samples still in flight, current output, run lengths.
    logic [WIDTH-1:0] m_hist [SYNC_STAGES];
    logic [WIDTH-1:0] m_out;
    int               m_run  [WIDTH];

    initial begin
        for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] = '0;
        m_out = '0;
        for (int k = 0; k < WIDTH; k++) m_run[k] = 0;
    end

    // Predicts the outputs after the coming posedge from the inputs now applied.
    task automatic model_edge(input logic r);
        exp_t             e;
        logic [WIDTH-1:0] s;
        int               neff;
        if (r) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] = '0;
            m_out = '0;
            for (int k = 0; k < WIDTH; k++) m_run[k] = 0;
            e.out = '0;
            e.chg = '0;
        end else begin
            // The level the filter sees was sampled SYNC_STAGES edges ago.
            s     = m_hist[SYNC_STAGES-1];
            neff  = (!debounce_en || debounce_cycles == 0) ? 1 : int'(debounce_cycles);
            e.chg = '0;
            for (int k = 0; k < WIDTH; k++) begin
                if (s[k] != m_out[k]) begin
                    m_run[k]++;
                    if (m_run[k] >= neff) begin
                        m_out[k] = s[k];
                        e.chg[k] = 1'b1;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            e.out = m_out;
            for (int k = SYNC_STAGES-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pin_in;
        end
        exp_q.push_back(e);
    endtask

    // One clock of stimulus, applied on the falling edge.
    task automatic drive(input logic [WIDTH-1:0] p, input logic en,
                         input logic [CNT_WIDTH-1:0] n, input logic r);
        @(negedge clk);
        pin_in          = p;
        debounce_en     = en;
        debounce_cycles = n;
        rst             = r;
        model_edge(r);
        if (r) begin
            #1;
            n_tests++;
            if (pin_out !== '0 || changed !== '0) begin
                n_fail++;
                $display("FAIL async_reset: got out=%h chg=%h, expected 00/00", pin_out, changed);
            end
        end
    endtask

    // Monitor: one expected entry per posedge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (pin_out !== e.out) begin
                    n_fail++;
                    $display("FAIL pin_out cycle %0d: got %h, expected %h", cyc_no, pin_out, e.out);
                end
                n_tests++;
                if (changed !== e.chg) begin
                    n_fail++;
                    $display("FAIL changed cycle %0d: got %h, expected %h", cyc_no, changed, e.chg);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] p;
        logic             en;
        logic [CNT_WIDTH-1:0] n;

        // 1: pins held high through reset release, N=4.
        repeat (2) drive(8'hFF, 1'b1, 16'd4, 1'b1);
        repeat (12) drive(8'hFF, 1'b1, 16'd4, 1'b0);

        // 2: short pulse on pin0 below an N=10 threshold is rejected.
        repeat (2) drive(8'h00, 1'b1, 16'd10, 1'b1);
        repeat (6) drive(8'h01, 1'b1, 16'd10, 1'b0);
        repeat (20) drive(8'h00, 1'b1, 16'd10, 1'b0);

        // 3: bypass, pin3 toggling every 3 cycles.
        repeat (2) drive(8'h00, 1'b0, 16'd10, 1'b1);
        p = 8'h00;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) p[3] = ~p[3];
            drive(p, 1'b0, 16'd10, 1'b0);
        end

        // 4: threshold lowered from 100 to 20 partway through a count.
        repeat (2) drive(8'h00, 1'b1, 16'd100, 1'b1);
        repeat (52) drive(8'h02, 1'b1, 16'd100, 1'b0);
        repeat (6) drive(8'h02, 1'b1, 16'd20, 1'b0);

        // 5: maximum threshold on pin2.
        repeat (2) drive(8'h00, 1'b1, 16'hFFFF, 1'b1);
        repeat (65540) drive(8'h04, 1'b1, 16'hFFFF, 1'b0);

        // 6: per-pin bounce patterns with a reset pulse in the middle.
        repeat (2) drive(8'h00, 1'b1, 16'd5, 1'b1);
        p = 8'h00;
        for (int k = 0; k < 80; k++) begin
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 2 + b) == 0) p[b] = ~p[b];
            drive(p, 1'b1, 16'd5, (k == 40 || k == 41) ? 1'b1 : 1'b0);
        end

        // Random phase: random levels, thresholds and bypass.
        en = 1'b1;
        n  = 16'd3;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                en = ($urandom_range(0, 3) != 0);
                n  = CNT_WIDTH'($urandom_range(0, 8));
            end
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 5) == 0) p[b] = ~p[b];
            drive(p, en, n, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
